bcd_countdown_timer: RTL and testbench
======================================

# bcd_countdown_timer

Parametrised multi-digit BCD countdown timer for the microwave cook-time path, successor to the single mod-10 digit counter. It holds a loadable MM:SS (or plain decimal) value and decrements one step per `tick` strobe, with borrow rippling across digits. A run/pause/done state machine and a one-cycle `done` pulse feed the controller and the 7-segment display path.

## Interface
- `DIGITS`, 4: number of BCD digits (2..8); digit 0 is least significant.
- `SEC_MODE`, 1: 1 makes digit 1 modulo 6 (seconds tens, MM:SS); 0 makes every digit modulo 10.

- `clk` input 1: single system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick` input 1: count strobe (e.g. 1 Hz enable), one `clk` cycle wide.
- `load` input 1: load `load_val` into the count.
- `load_val` input 4*DIGITS: packed BCD preset, digit k at [4k+3:4k].
- `start` input 1: begin or resume counting.
- `pause` input 1: hold the count.
- `clear` input 1: synchronous abort to IDLE with count 0.
- `count` output 4*DIGITS: current BCD value, registered.
- `running` output 1: high in RUN.
- `zero` output 1: count == 0, decoded from `count`.
- `done` output 1: one-cycle pulse on reaching zero.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset puts the block in IDLE with `count`=0, `running`=0, `done`=0, and `zero`=1.
- Control priority in every state: `clear` > `load` > `pause` > `start`.
- `clear`: any state -> IDLE, `count`=0.
- `load`: accepted in IDLE, PAUSED and DONE, and moves the block to IDLE. Ignored in RUN.
  - Each loaded digit saturates to modulus-1 if out of range (e.g. 0xC in a mod-6 digit loads 5).
- `start`:
  - IDLE or PAUSED -> RUN when `count` != 0.
  - With `count` == 0 the block stays in its state and `done` is not pulsed.
  - `start` in DONE is ignored until a `load`.
- `pause`: RUN -> PAUSED. Ignored elsewhere.
- `tick` in RUN decrements `count` by one:
  - Digit 0 always decrements.
  - Digit k decrements only if all lower digits were 0, and a decrementing 0 wraps to modulus-1.
  - Example: 01:00 -> 00:59 in MM:SS.
- The decrement that produces 0 moves RUN -> DONE and asserts `done` for exactly one cycle. The count then stays 0.
- `tick` outside RUN has no effect.
- `tick` coinciding with `pause`, `clear` or `load`: the control wins and no decrement occurs that cycle.
- Reset mid-RUN: immediate return to the reset values. There is no resume.

## Timing
- All outputs except `zero` are registered.
- `count` changes in the cycle after the `clk` edge that samples `tick` high, so latency is 1 cycle.
- `done` is high during the same cycle in which `count` first reads 0 and the state is DONE.
- `running` goes high 1 cycle after `start` is sampled and low 1 cycle after `pause`, `clear` or the final tick.
- `load` takes effect on `count` 1 cycle after it is sampled.
- Back-to-back ticks (tick every cycle) are legal; the counter decrements every cycle.

## Structure
- Shared package `timer_pkg` holds:
  - the state enum (IDLE/RUN/PAUSED/DONE);
  - `BCD_W` = 4;
  - `MOD_DEC` = 10 and `MOD_SEC_TENS` = 6.
- Sub-module `bcd_digit_dn`, one BCD digit:
  - Parameter: modulus.
  - Inputs: `load`, `d`, decrement enable `dec_in`.
  - Outputs: digit `q`, borrow-out `bo` (q == 0 && dec_in).
  - Contains the load saturation logic.
- The top level instantiates DIGITS digits in a generate loop chained by borrow, plus the FSM.

## Test plan
- Reset with `load_val`=0x0130 applied: `count`=0, `zero`=1, `done`=0 during and after reset. Then `load` gives `count`=0x0130 one cycle later, state IDLE.
- MM:SS borrow: load 0x0100, `start`, one `tick` -> `count`=0x0059. Next tick -> 0x0058. No intermediate 0x00A0 or 0x0099 value appears.
- Full run: load 0x0003, `start`, 3 ticks -> `count`=0, `done` high exactly 1 cycle, state DONE. Further ticks leave `count`=0 with no second `done`.
- Pause and simultaneous events, with load 0x0010 and RUN:
  - `pause` with `tick` in the same cycle -> `count` stays 0x0010, state PAUSED.
  - A tick while PAUSED has no effect.
  - `start` then a tick -> 0x0009.
- Priority and saturation:
  - `load`=0x00C9 while in RUN -> ignored.
  - After `pause`, the same load -> `count`=0x0059.
  - `clear` with `load` in the same cycle -> `count`=0.
- Zero start and reset mid-run: `start` with `count`=0 -> no RUN, no `done`. Load 0x0200, run 5 ticks, then assert `rst_n`=0 asynchronously between edges -> `count`=0 and `running`=0 immediately.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;
  localparam int BCD_W        = 4;
  localparam int MOD_DEC      = 10;
  localparam int MOD_SEC_TENS = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } timer_state_e;

  // Clamp an out-of-range preset digit to the largest legal value.
  function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d,
                                                 input int modulus);
    if (int'(d) > modulus - 1) return BCD_W'(modulus - 1);
    return d;
  endfunction
endpackage

// File: rtl/bcd_digit_dn.sv
// One down-counting BCD digit with saturating load and borrow out.
// Latency 1 cycle; no backpressure, digit steps whenever dec_in is high.
module bcd_digit_dn
  import timer_pkg::*;
#(
  parameter int MODULUS = MOD_DEC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  input  logic             dec_in,
  output logic [BCD_W-1:0] q,
  output logic             bo
);
  logic [BCD_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = sat_digit(d, MODULUS);
    end else if (dec_in) begin
      q_d = (q_q == '0) ? BCD_W'(MODULUS - 1) : q_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q  = q_q;
  assign bo = (q_q == '0) && dec_in;
endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause/done control and done pulse.
// Latency 1 cycle from tick/load/start to outputs; no backpressure, strobes act immediately.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SEC_MODE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    zero,
  output logic                    done
);
  localparam int W = BCD_W * DIGITS;

  timer_state_e state_d, state_q;
  logic         done_d, done_q;
  logic         running_d, running_q;
  logic         load_acc, do_dec, last_step;
  logic [DIGITS:0] dec;
  logic         unused_top_bo;

  assign dec[0]        = do_dec;
  assign unused_top_bo = dec[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    localparam int M = (SEC_MODE != 0 && k == 1) ? MOD_SEC_TENS : MOD_DEC;
    bcd_digit_dn #(.MODULUS(M)) u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clear),
      .load   (load_acc),
      .d      (load_val[BCD_W*k +: BCD_W]),
      .dec_in (dec[k]),
      .q      (count[BCD_W*k +: BCD_W]),
      .bo     (dec[k+1])
    );
  end

  assign zero = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (load && state_q != ST_RUN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause)          state_d = ST_PAUSED;
          else if (last_step) state_d = ST_DONE;
        end
        ST_IDLE, ST_PAUSED: begin
          if (start && !zero) state_d = ST_RUN;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // A load in RUN changes nothing, but still swallows a coincident tick.
  always_comb begin
    load_acc  = load && !clear && (state_q != ST_RUN);
    do_dec    = (state_q == ST_RUN) && tick && !clear && !load && !pause;
    last_step = do_dec && (count == W'(1));
    done_d    = last_step;
    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  assign done    = done_q;
  assign running = running_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer against a mixed-radix integer model.
module tb_bcd_countdown_timer;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick, load, start, pause, clear;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         running, zero, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(DIGITS), .SEC_MODE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .count    (count),
    .running  (running),
    .zero     (zero),
    .done     (done)
  );

  // Model: state 0 idle, 1 run, 2 paused, 3 done; count kept as a plain integer.
  typedef struct packed {
    logic [1:0] st;
    logic       dn;
    int         val;
  } model_t;

  model_t m;

  function automatic int modk(input int k);
    return (k == 1) ? 6 : 10;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % modk(k));
      rem         = rem / modk(k);
    end
    return r;
  endfunction

  function automatic int from_load(input logic [W-1:0] lv);
    int v, w, d;
    v = 0;
    w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(lv[4*k +: 4]);
      if (d > modk(k) - 1) d = modk(k) - 1;
      v = v + d * w;
      w = w * modk(k);
    end
    return v;
  endfunction

  function automatic model_t nxt(input model_t c, input logic t, l, s, p, cl,
                                 input logic [W-1:0] lv);
    model_t n;
    n    = c;
    n.dn = 1'b0;
    if (cl) begin
      n.st  = 2'd0;
      n.val = 0;
    end else if (l && c.st != 2'd1) begin
      n.st  = 2'd0;
      n.val = from_load(lv);
    end else if (c.st == 2'd1) begin
      if (p) begin
        n.st = 2'd2;
      end else if (t && !l) begin
        n.val = c.val - 1;
        if (n.val == 0) begin
          n.st = 2'd3;
          n.dn = 1'b1;
        end
      end
    end else if (s && (c.st == 2'd0 || c.st == 2'd2) && c.val != 0) begin
      n.st = 2'd1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= nxt(m, tick, load, start, pause, clear, load_val);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("model_count",   32'(count),   32'(to_bcd(m.val)));
    chk("model_running", 32'(running), 32'(m.st == 2'd1));
    chk("model_zero",    32'(zero),    32'(m.val == 0));
    chk("model_done",    32'(done),    32'(m.dn));
  endtask

  // Called at a falling edge: drives one cycle of strobes, checks at the next falling edge.
  task automatic drive(input logic t, l, s, p, c, input logic [W-1:0] lv);
    tick     = t;
    load     = l;
    start    = s;
    pause    = p;
    clear    = c;
    load_val = lv;
    @(negedge clk);
    tick  = 1'b0;
    load  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    clear = 1'b0;
    cmp_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, load_val);
  endtask

  initial begin
    rst_n    = 1'b0;
    tick     = 1'b0;
    load     = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    clear    = 1'b0;
    load_val = 16'h0130;
    @(negedge clk);

    // Reset with a preset present on load_val
    drive(0, 1, 0, 0, 0, 16'h0130);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_zero",  32'(zero),  32'h1);
    chk("rst_done",  32'(done),  32'h0);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_count", 32'(count), 32'h0);
    drive(0, 1, 0, 0, 0, 16'h0130);
    chk("load_0130",  32'(count),   32'h0130);
    chk("load_idle",  32'(running), 32'h0);

    // MM:SS borrow
    drive(0, 1, 0, 0, 0, 16'h0100);
    drive(0, 0, 1, 0, 0, 16'h0100);
    chk("start_run", 32'(running), 32'h1);
    drive(1, 0, 0, 0, 0, 16'h0100);
    chk("borrow_0059", 32'(count), 32'h0059);
    drive(1, 0, 0, 0, 0, 16'h0100);
    chk("tick_0058", 32'(count), 32'h0058);

    // Full run to zero
    drive(0, 0, 0, 0, 1, 16'h0000);
    drive(0, 1, 0, 0, 0, 16'h0003);
    drive(0, 0, 1, 0, 0, 16'h0003);
    drive(1, 0, 0, 0, 0, 16'h0003);
    drive(1, 0, 0, 0, 0, 16'h0003);
    chk("count_1", 32'(count), 32'h0001);
    drive(1, 0, 0, 0, 0, 16'h0003);
    chk("final_count", 32'(count),   32'h0);
    chk("final_done",  32'(done),    32'h1);
    chk("final_run",   32'(running), 32'h0);
    idle(1);
    chk("done_one_cycle", 32'(done), 32'h0);
    drive(1, 0, 0, 0, 0, 16'h0003);
    chk("tick_in_done", 32'(count), 32'h0);
    drive(0, 0, 1, 0, 0, 16'h0003);
    chk("start_in_done", 32'(running), 32'h0);

    // Pause with simultaneous tick
    drive(0, 1, 0, 0, 0, 16'h0010);
    drive(0, 0, 1, 0, 0, 16'h0010);
    drive(1, 0, 0, 1, 0, 16'h0010);
    chk("pause_tick_count", 32'(count),   32'h0010);
    chk("pause_tick_run",   32'(running), 32'h0);
    drive(1, 0, 0, 0, 0, 16'h0010);
    chk("tick_paused", 32'(count), 32'h0010);
    drive(0, 0, 1, 0, 0, 16'h0010);
    drive(1, 0, 0, 0, 0, 16'h0010);
    chk("resume_0009", 32'(count), 32'h0009);

    // Priority and load saturation
    drive(0, 1, 0, 0, 0, 16'h00C9);
    chk("load_in_run", 32'(count),   32'h0009);
    chk("run_kept",    32'(running), 32'h1);
    drive(0, 0, 0, 1, 0, 16'h00C9);
    drive(0, 1, 0, 0, 0, 16'h00C9);
    chk("sat_0059", 32'(count), 32'h0059);
    drive(0, 1, 0, 0, 1, 16'h0123);
    chk("clear_over_load", 32'(count), 32'h0);

    // Zero start, then async reset mid-run
    drive(0, 0, 1, 0, 0, 16'h0000);
    chk("zero_start_run",  32'(running), 32'h0);
    chk("zero_start_done", 32'(done),    32'h0);
    drive(0, 1, 0, 0, 0, 16'h0200);
    drive(0, 0, 1, 0, 0, 16'h0200);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 16'h0200);
    chk("five_ticks", 32'(count), 32'h0155);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count",   32'(count),   32'h0);
    chk("async_running", 32'(running), 32'h0);
    chk("async_zero",    32'(zero),    32'h1);
    @(negedge clk);
    cmp_all();
    rst_n = 1'b1;
    drive(1, 0, 1, 0, 0, 16'h0200);
    chk("no_resume", 32'(count), 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
